// File: rtl/link_pkg.sv
// Shared constants and state encoding for the on-chip byte link.
// Used by the link master, the receiving slave and link_top so that
// byte width, default frame length and the handshake state encoding
// stay consistent across both ends of the link.
package link_pkg;

    localparam int LINK_W          = 8;   // bits per link byte
    localparam int LINK_NBYTES_DEF = 4;   // default bytes per frame
    localparam int LINK_HOLD_W     = 4;   // wide enough for ACK_HOLD up to 15

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } link_state_t;

endpackage

// File: rtl/link_slave_rx_if.sv
// 4-phase req/ack byte link between the link master and the receiving slave.
//   req     : master request, data_in valid while high
//   data_in : byte from master
//   ack     : acknowledge from slave
// Modports: master drives req/data_in, slave drives ack.
interface link_slave_rx_if;
    import link_pkg::*;

    logic              req;
    logic [LINK_W-1:0] data_in;
    logic              ack;

    modport master (output req, output data_in, input ack);
    modport slave  (input req, input data_in, output ack);

endinterface

// File: rtl/link_slave_rx.sv
// Receiving end of the on-chip byte link. Accepts bytes over a 4-phase
// req/ack handshake and assembles NBYTES of them into one frame.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   lnk         : slave side of the req/data_in/ack handshake
//   frame       : last completed frame, byte 0 in bits [7:0]
//   frame_valid : one-cycle pulse when frame updates
//   byte_cnt    : bytes captured in the frame under construction
module link_slave_rx
    import link_pkg::*;
#(
    parameter int  NBYTES   = LINK_NBYTES_DEF,
    parameter int  ACK_HOLD = 1,
    localparam int CNT_W    = $clog2(NBYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    link_slave_rx_if.slave           lnk,
    output logic [LINK_W*NBYTES-1:0] frame,
    output logic                     frame_valid,
    output logic [CNT_W-1:0]         byte_cnt
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    link_state_t             state, state_next;
    logic [LINK_HOLD_W-1:0]  hold, hold_next;
    logic                    capture;
    logic                    done;
    logic [IDX_W-1:0]        slot;

    // Assembly buffer is kept apart from frame so partial frames never show.
    logic [NBYTES-1:0][LINK_W-1:0] asm_buf;

    assign slot    = byte_cnt[IDX_W-1:0];
    assign lnk.ack = (state == ACK);

    always_comb begin
        state_next = state;
        hold_next  = hold;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (lnk.req) begin
                    capture    = 1'b1;
                    hold_next  = LINK_HOLD_W'(ACK_HOLD);
                    state_next = ACK;
                end
            end
            ACK: begin
                if (hold != '0) begin
                    hold_next = hold - 1'b1;
                end
                // Exit is judged on the post-decrement count, so ack is high
                // for exactly ACK_HOLD cycles when req is already low.
                if ((hold <= LINK_HOLD_W'(1)) && !lnk.req) begin
                    state_next = IDLE;
                    done       = (byte_cnt == CNT_W'(NBYTES));
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            byte_cnt    <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_next;
            hold        <= hold_next;
            frame_valid <= done;
            if (capture) begin
                byte_cnt <= byte_cnt + 1'b1;
            end else if (done) begin
                byte_cnt <= '0;
            end
            if (done) begin
                frame <= asm_buf;
            end
        end
    end

    // Data-only storage; byte_cnt reset is what discards a partial frame.
    always_ff @(posedge clk) begin
        if (capture) begin
            asm_buf[slot] <= lnk.data_in;
        end
    end

endmodule

// File: tb/tb_link_slave_rx.sv
// Bench for link_slave_rx: two instances (ACK_HOLD=1 and ACK_HOLD=3) share
// one master stimulus and are checked every cycle against a timestamp-based
// model, plus literal expectations for the directed scenarios.
module tb_link_slave_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_drv;
    logic [7:0]  data_drv;

    link_slave_rx_if lnk1 ();
    link_slave_rx_if lnk3 ();

    assign lnk1.req     = req_drv;
    assign lnk1.data_in = data_drv;
    assign lnk3.req     = req_drv;
    assign lnk3.data_in = data_drv;

    logic [31:0] frame1, frame3;
    logic        fv1, fv3;
    logic [2:0]  cnt1, cnt3;

    link_slave_rx #(.NBYTES(4), .ACK_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .lnk(lnk1),
        .frame(frame1), .frame_valid(fv1), .byte_cnt(cnt1));

    link_slave_rx #(.NBYTES(4), .ACK_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .lnk(lnk3),
        .frame(frame3), .frame_valid(fv3), .byte_cnt(cnt3));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Model: a handshake opens when req is seen high while idle; it closes at
    // the first edge at least H cycles after it opened with req seen low.
    int          cyc = 0;
    bit          m_ack   [2];
    int          m_cnt   [2];
    int          m_rise  [2];
    logic [7:0]  m_buf   [2][4];
    logic [31:0] m_frame [2];
    bit          m_fv    [2];
    int          h;

    function automatic logic [31:0] pack(input int d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) f[8*i +: 8] = m_buf[d][i];
        return f;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_ack[d] = 0; m_cnt[d] = 0; m_frame[d] = '0; m_fv[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                h = (d == 0) ? 1 : 3;
                m_fv[d] = 0;
                if (!m_ack[d]) begin
                    if (req_drv) begin
                        m_buf[d][m_cnt[d]] = data_drv;
                        m_cnt[d]++;
                        m_ack[d]  = 1;
                        m_rise[d] = cyc;
                    end
                end else if ((cyc - m_rise[d]) >= h && !req_drv) begin
                    m_ack[d] = 0;
                    if (m_cnt[d] == 4) begin
                        m_frame[d] = pack(d);
                        m_fv[d]    = 1;
                        m_cnt[d]   = 0;
                    end
                end
            end
        end
    end

    int fv_total1 = 0;
    int len1 = 0, len3 = 0, last_len1 = 0, last_len3 = 0;

    always @(posedge clk) begin
        #1;
        chk("ack1",   lnk1.ack, m_ack[0]);
        chk("cnt1",   cnt1,     m_cnt[0]);
        chk("frame1", frame1,   m_frame[0]);
        chk("fv1",    fv1,      m_fv[0]);
        chk("ack3",   lnk3.ack, m_ack[1]);
        chk("cnt3",   cnt3,     m_cnt[1]);
        chk("frame3", frame3,   m_frame[1]);
        chk("fv3",    fv3,      m_fv[1]);
        if (fv1) fv_total1++;
        if (lnk1.ack) len1++;
        else if (len1 != 0) begin last_len1 = len1; len1 = 0; end
        if (lnk3.ack) len3++;
        else if (len3 != 0) begin last_len3 = len3; len3 = 0; end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((lnk1.ack || lnk3.ack) && n < 60) begin @(negedge clk); n++; end
        if (lnk1.ack || lnk3.ack) expire("ack_fall");
    endtask

    task automatic raise_req(input logic [7:0] b, input bit chk_lat);
        int n;
        @(negedge clk);
        req_drv  = 1'b1;
        data_drv = b;
        n = 0;
        while (!lnk1.ack && n < 60) begin @(negedge clk); n++; end
        if (!lnk1.ack) expire("ack_rise");
        else if (chk_lat) chk("ack_latency", n, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit chk_lat);
        raise_req(b, chk_lat);
        repeat (hold) begin @(negedge clk); data_drv = 8'($urandom); end
        req_drv = 1'b0;
        wait_idle();
    endtask

    task automatic send_frame(input logic [31:0] f, input int hold);
        for (int i = 0; i < 4; i++) send_byte(f[8*i +: 8], hold, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    int fv_start;

    initial begin
        rst      = 1'b1;
        req_drv  = 1'b0;
        data_drv = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack",   lnk1.ack, 1'b0);
        chk("rst_cnt",   cnt1,     3'd0);
        chk("rst_frame", frame1,   32'h0);
        chk("rst_fv",    fv1,      1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame with ack-latency check on every byte.
        fv_start = fv_total1;
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h3C, 0, 1'b1);
        send_byte(8'hF0, 0, 1'b1);
        send_byte(8'h0F, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("nom_frame1",  frame1,     32'h0FF03CA5);
        chk("nom_frame3",  frame3,     32'h0FF03CA5);
        chk("nom_model",   m_frame[0], 32'h0FF03CA5);
        chk("nom_pulses",  fv_total1 - fv_start, 1);

        // Slow master: req high 5 cycles per byte, data scrambled during ack.
        fv_start = fv_total1;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h12 + 8'(i * 8'h22), 4, 1'b0);
            chk("slow_len1", last_len1, 5);
            chk("slow_len3", last_len3, 5);
        end
        repeat (2) @(negedge clk);
        chk("slow_frame",  frame1, 32'h78563412);
        chk("slow_pulses", fv_total1 - fv_start, 1);

        // Early req drop: ack length tracks ACK_HOLD.
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 0, 1'b0);
            chk("hold_len1", last_len1, 1);
            chk("hold_len3", last_len3, 3);
        end
        repeat (2) @(negedge clk);
        chk("hold_frame3", frame3, 32'h04030201);

        // Back-to-back frames.
        send_frame(32'h44332211, 0);
        chk("b2b_frame_a", frame1, 32'h44332211);
        chk("b2b_wrap",    cnt1,   3'd0);
        send_frame(32'h88776655, 0);
        chk("b2b_frame_b", frame1, 32'h88776655);
        chk("b2b_frame_b3", frame3, 32'h88776655);

        // Asynchronous reset mid-frame with ack high.
        send_byte(8'hDE, 0, 1'b0);
        send_byte(8'hAD, 0, 1'b0);
        raise_req(8'hBE, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_ack1",  lnk1.ack, 1'b0);
        chk("arst_ack3",  lnk3.ack, 1'b0);
        chk("arst_cnt",   cnt1,     3'd0);
        chk("arst_frame", frame1,   32'h0);
        @(negedge clk);
        req_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(32'hC4C3C2C1, 1);
        chk("arst_clean", frame1, 32'hC4C3C2C1);
        chk("arst_clean3", frame3, 32'hC4C3C2C1);

        // Stuck req: one capture only, ack held.
        raise_req(8'h9A, 1'b0);
        repeat (10) begin @(negedge clk); data_drv = 8'($urandom); end
        chk("stuck_cnt1", cnt1,     3'd1);
        chk("stuck_ack1", lnk1.ack, 1'b1);
        chk("stuck_cnt3", cnt3,     3'd1);
        chk("stuck_ack3", lnk3.ack, 1'b1);
        req_drv = 1'b0;
        wait_idle();
        send_byte(8'hBC, 0, 1'b0);
        send_byte(8'hDE, 2, 1'b0);
        send_byte(8'hF0, 1, 1'b0);
        repeat (2) @(negedge clk);
        chk("stuck_frame", frame1, 32'hF0DEBC9A);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(8'($urandom), $urandom_range(0, 5), 1'b1);
            end
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
